// File: rtl/pool_mxm_replay_buf_pkg.sv
// rtl/pool_mxm_replay_buf_pkg.sv - shared widths, thresholds and FSM encoding for the MXM replay buffer
`ifndef P
`define P 64
`endif
`ifndef MXM_DEPTH
`define MXM_DEPTH 512
`endif

package pool_mxm_replay_buf_pkg;
  localparam int DEF_DATA_WIDTH = `P * 2 * 8;
  localparam int DEF_DEPTH      = `MXM_DEPTH;
  localparam int DEF_AE_THRESH  = 1;
  localparam int DEF_PF_THRESH  = 448;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_REWIND = 1'b1
  } state_e;
endpackage

// File: rtl/pool_mxm_replay_buf_if.sv
// rtl/pool_mxm_replay_buf_if.sv - X-bus write side and MXM read side of the replay buffer
interface pool_mxm_replay_buf_if
  import pool_mxm_replay_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  prog_full;
  logic                  mxm_rd_en;
  logic                  mxm_rd_last_rnd;
  logic [DATA_WIDTH-1:0] mxm_dout;
  logic                  mxm_dout_vld;
  logic                  mxm_empty;
  logic                  mxm_almost_empty;

  modport master (
    output wr_en, din, mxm_rd_en, mxm_rd_last_rnd,
    input  prog_full, mxm_dout, mxm_dout_vld, mxm_empty, mxm_almost_empty
  );

  modport slave (
    input  wr_en, din, mxm_rd_en, mxm_rd_last_rnd,
    output prog_full, mxm_dout, mxm_dout_vld, mxm_empty, mxm_almost_empty
  );
endinterface

// File: rtl/pool_mxm_replay_buf_sdp_ram.sv
// rtl/pool_mxm_replay_buf_sdp_ram.sv - simple dual-port RAM with registered read port
module mxm_sdp_ram #(
  parameter int    WIDTH     = 1024,
  parameter int    DEPTH     = 512,
  parameter int    AW        = $clog2(DEPTH),
  parameter string RAM_STYLE = "block"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  // Read data holds between reads; only the output register is reset.
  if (RAM_STYLE == "block") begin : g_block
    (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
    end
  end else begin : g_dist
    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/pool_mxm_replay_buf.sv
// rtl/pool_mxm_replay_buf.sv - windowed replay vector buffer feeding the Pool MXM array controller
// Optional round/window statistics ports: MXM_REPLAY_STATS_EN
module pool_mxm_replay_buf
  import pool_mxm_replay_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AE_THRESH  = DEF_AE_THRESH,
  parameter int PF_THRESH  = DEF_PF_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_pulse,
  input  logic [15:0]           vec_size_minus_1,
  pool_mxm_replay_buf_if.slave  bus,
  output logic                  wr_overflow
`ifdef MXM_REPLAY_STATS_EN
  ,
  output logic [15:0]           rnd_cnt,
  output logic [15:0]           win_done_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  state_e        state, state_nxt;
  logic [PW-1:0] wr_ptr, base_ptr, rd_ptr;
  logic [PW-1:0] occupied, readable;
  logic [15:0]   win_cnt, vsm1_q;
  logic          full, rd_acc, wr_acc, end_rnd;

  assign occupied = wr_ptr - base_ptr;
  assign readable = wr_ptr - rd_ptr;
  assign full     = (occupied == PW'(DEPTH));

  assign bus.mxm_empty        = (readable == '0) || (state == ST_REWIND);
  assign bus.mxm_almost_empty = (readable <= PW'(AE_THRESH));
  assign bus.prog_full        = (occupied >= PW'(PF_THRESH));

  // start_pulse swallows any same-cycle traffic.
  assign rd_acc  = bus.mxm_rd_en && !bus.mxm_empty && !start_pulse;
  assign wr_acc  = bus.wr_en && !full && !start_pulse;
  assign end_rnd = rd_acc && (win_cnt == vsm1_q);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (end_rnd && !bus.mxm_rd_last_rnd) state_nxt = ST_REWIND;
      ST_REWIND: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
    if (start_pulse) state_nxt = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr           <= '0;
      base_ptr         <= '0;
      rd_ptr           <= '0;
      win_cnt          <= '0;
      vsm1_q           <= '0;
      wr_overflow      <= 1'b0;
      bus.mxm_dout_vld <= 1'b0;
    end else if (start_pulse) begin
      wr_ptr           <= '0;
      base_ptr         <= '0;
      rd_ptr           <= '0;
      win_cnt          <= '0;
      vsm1_q           <= vec_size_minus_1;
      wr_overflow      <= 1'b0;
      bus.mxm_dout_vld <= 1'b0;
    end else begin
      bus.mxm_dout_vld <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (bus.wr_en && full) wr_overflow <= 1'b1;
      if (rd_acc) begin
        if (end_rnd) begin
          win_cnt <= '0;
          if (bus.mxm_rd_last_rnd) begin
            base_ptr <= rd_ptr + PTR_ONE;
            rd_ptr   <= rd_ptr + PTR_ONE;
          end else begin
            rd_ptr   <= base_ptr;
          end
        end else begin
          rd_ptr  <= rd_ptr + PTR_ONE;
          win_cnt <= win_cnt + 16'd1;
        end
      end
    end
  end

`ifdef MXM_REPLAY_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || start_pulse) begin
      rnd_cnt      <= '0;
      win_done_cnt <= '0;
    end else if (end_rnd) begin
      if (rnd_cnt != 16'hFFFF) rnd_cnt <= rnd_cnt + 16'd1;
      if (bus.mxm_rd_last_rnd && win_done_cnt != 16'hFFFF)
        win_done_cnt <= win_done_cnt + 16'd1;
    end
  end
`endif

  mxm_sdp_ram #(
    .WIDTH     (DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW),
    .RAM_STYLE ("block")
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.din),
    .re    (rd_acc),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (bus.mxm_dout)
  );
endmodule

// File: tb/tb_pool_mxm_replay_buf.sv
// tb/tb_pool_mxm_replay_buf.sv - directed self-checking bench for pool_mxm_replay_buf
module tb_pool_mxm_replay_buf;
  import pool_mxm_replay_buf_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_pulse;
  logic [15:0] vsm1;
  logic        wr_overflow;
  int          tests = 0;
  int          fails = 0;
`ifdef MXM_REPLAY_STATS_EN
  logic [15:0] rnd_cnt, win_done_cnt;
`endif

  pool_mxm_replay_buf_if #(.DATA_WIDTH(DW)) bus ();

  pool_mxm_replay_buf dut (
    .clk              (clk),
    .rst              (rst),
    .start_pulse      (start_pulse),
    .vec_size_minus_1 (vsm1),
    .bus              (bus),
    .wr_overflow      (wr_overflow)
`ifdef MXM_REPLAY_STATS_EN
    ,
    .rnd_cnt          (rnd_cnt),
    .win_done_cnt     (win_done_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mkv(input int i);
    logic [31:0] w;
    w = 32'(i) ^ 32'h5A00_0000;
    return {(DW/32){w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] v);
    start_pulse = 1'b1;
    vsm1        = v;
    tick();
    start_pulse = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests++; if (bus.mxm_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", bus.mxm_empty); end
    tests++; if (bus.mxm_almost_empty !== 1'b1) begin fails++; $display("FAIL reset_aempty got %b exp 1", bus.mxm_almost_empty); end
    tests++; if (bus.prog_full !== 1'b0) begin fails++; $display("FAIL reset_pfull got %b exp 0", bus.prog_full); end
    tests++; if (bus.mxm_dout_vld !== 1'b0) begin fails++; $display("FAIL reset_vld got %b exp 0", bus.mxm_dout_vld); end
    tests++; if (wr_overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", wr_overflow); end
    tests++; if (bus.mxm_dout !== '0) begin fails++; $display("FAIL reset_dout got %h exp 0", bus.mxm_dout[31:0]); end
  endtask

  task automatic test_replay();
    int exp_vld [9];
    int exp_idx [9];
    exp_vld = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
    exp_idx = '{0, 1, 2, 3, 0, 0, 1, 2, 3};
    do_start(16'd3);
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1; bus.din = mkv(i); tick();
    end
    bus.wr_en = 1'b0;
    tests++; if (bus.mxm_almost_empty !== 1'b0) begin fails++; $display("FAIL replay_aempty4 got %b exp 0", bus.mxm_almost_empty); end
    for (int c = 0; c < 9; c++) begin
      bus.mxm_rd_en = 1'b1;
      bus.mxm_rd_last_rnd = (c >= 5);
      if (c == 4) begin
        tests++; if (bus.mxm_empty !== 1'b1) begin fails++; $display("FAIL replay_rewind_empty got %b exp 1", bus.mxm_empty); end
      end
      tick();
      tests++;
      if (bus.mxm_dout_vld !== exp_vld[c][0]) begin
        fails++; $display("FAIL replay_vld[%0d] got %b exp %0d", c, bus.mxm_dout_vld, exp_vld[c]);
      end else if (exp_vld[c] == 1 && bus.mxm_dout !== mkv(exp_idx[c])) begin
        fails++; $display("FAIL replay_dout[%0d] got %h exp %h", c, bus.mxm_dout[31:0], mkv(exp_idx[c]) & 32'hFFFFFFFF);
      end
    end
    bus.mxm_rd_en = 1'b0; bus.mxm_rd_last_rnd = 1'b0;
    tests++; if (bus.mxm_empty !== 1'b1) begin fails++; $display("FAIL replay_end_empty got %b exp 1", bus.mxm_empty); end
    tests++; if (bus.prog_full !== 1'b0) begin fails++; $display("FAIL replay_end_pfull got %b exp 0", bus.prog_full); end
`ifdef MXM_REPLAY_STATS_EN
    tests++; if (rnd_cnt !== 16'd2) begin fails++; $display("FAIL replay_rnd_cnt got %0d exp 2", rnd_cnt); end
    tests++; if (win_done_cnt !== 16'd1) begin fails++; $display("FAIL replay_win_cnt got %0d exp 1", win_done_cnt); end
`endif
  endtask

  task automatic test_wrap();
    do_start(16'd0);
    for (int i = 0; i < 600; i++) begin
      bus.wr_en = 1'b1; bus.din = mkv(1000 + i); bus.mxm_rd_en = 1'b0;
      tick();
      bus.wr_en = 1'b0; bus.mxm_rd_en = 1'b1; bus.mxm_rd_last_rnd = 1'b1;
      tick();
      bus.mxm_rd_en = 1'b0;
      tests++;
      if (bus.mxm_dout_vld !== 1'b1 || bus.mxm_dout !== mkv(1000 + i)) begin
        fails++; $display("FAIL wrap_data[%0d] vld %b got %h exp %h", i, bus.mxm_dout_vld, bus.mxm_dout[31:0], mkv(1000 + i) & 32'hFFFFFFFF);
      end
    end
    bus.mxm_rd_last_rnd = 1'b0;
    tests++; if (wr_overflow !== 1'b0) begin fails++; $display("FAIL wrap_ovf got %b exp 0", wr_overflow); end
    tests++; if (bus.mxm_empty !== 1'b1) begin fails++; $display("FAIL wrap_empty got %b exp 1", bus.mxm_empty); end
  endtask

  task automatic test_fill();
    logic [DW-1:0] exp;
    do_start(16'd3);
    for (int i = 0; i < 512; i++) begin
      bus.wr_en = 1'b1; bus.din = mkv(i); tick();
      if (i == 446) begin
        tests++; if (bus.prog_full !== 1'b0) begin fails++; $display("FAIL fill_pf447 got %b exp 0", bus.prog_full); end
      end
      if (i == 447) begin
        tests++; if (bus.prog_full !== 1'b1) begin fails++; $display("FAIL fill_pf448 got %b exp 1", bus.prog_full); end
      end
    end
    tests++; if (wr_overflow !== 1'b0) begin fails++; $display("FAIL fill_ovf512 got %b exp 0", wr_overflow); end
    bus.din = mkv(777); tick();
    bus.wr_en = 1'b0;
    tests++; if (wr_overflow !== 1'b1) begin fails++; $display("FAIL fill_ovf513 got %b exp 1", wr_overflow); end
    bus.mxm_rd_en = 1'b1; bus.mxm_rd_last_rnd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (bus.mxm_dout_vld !== 1'b1 || bus.mxm_dout !== mkv(k)) begin
        fails++; $display("FAIL fill_rd[%0d] vld %b got %h exp %h", k, bus.mxm_dout_vld, bus.mxm_dout[31:0], mkv(k) & 32'hFFFFFFFF);
      end
    end
    bus.mxm_rd_en = 1'b0;
    bus.wr_en = 1'b1; bus.din = mkv(999); tick();
    bus.wr_en = 1'b0;
    bus.mxm_rd_en = 1'b1;
    for (int k = 0; k < 509; k++) begin
      tick();
      exp = (k < 508) ? mkv(4 + k) : mkv(999);
      tests++;
      if (bus.mxm_dout_vld !== 1'b1 || bus.mxm_dout !== exp) begin
        fails++; $display("FAIL drain_rd[%0d] vld %b got %h exp %h", k, bus.mxm_dout_vld, bus.mxm_dout[31:0], exp[31:0]);
      end
    end
    bus.mxm_rd_en = 1'b0; bus.mxm_rd_last_rnd = 1'b0;
    tests++; if (bus.mxm_empty !== 1'b1) begin fails++; $display("FAIL drain_empty got %b exp 1", bus.mxm_empty); end
    tests++; if (bus.prog_full !== 1'b0) begin fails++; $display("FAIL drain_pfull got %b exp 0", bus.prog_full); end
  endtask

  task automatic test_simul();
    do_start(16'd7);
    bus.wr_en = 1'b1; bus.din = mkv(50); tick();
    bus.wr_en = 1'b0;
    tests++; if (bus.mxm_almost_empty !== 1'b1 || bus.mxm_empty !== 1'b0) begin
      fails++; $display("FAIL simul_pre ae %b e %b exp ae 1 e 0", bus.mxm_almost_empty, bus.mxm_empty);
    end
    bus.mxm_rd_en = 1'b1; bus.mxm_rd_last_rnd = 1'b0;
    bus.wr_en = 1'b1; bus.din = mkv(51);
    tick();
    bus.mxm_rd_en = 1'b0; bus.wr_en = 1'b0;
    tests++; if (bus.mxm_dout_vld !== 1'b1 || bus.mxm_dout !== mkv(50)) begin
      fails++; $display("FAIL simul_rd vld %b got %h exp %h", bus.mxm_dout_vld, bus.mxm_dout[31:0], mkv(50) & 32'hFFFFFFFF);
    end
    tests++; if (bus.mxm_almost_empty !== 1'b1 || bus.mxm_empty !== 1'b0) begin
      fails++; $display("FAIL simul_post ae %b e %b exp ae 1 e 0", bus.mxm_almost_empty, bus.mxm_empty);
    end
    bus.mxm_rd_en = 1'b1; tick(); bus.mxm_rd_en = 1'b0;
    tests++; if (bus.mxm_dout_vld !== 1'b1 || bus.mxm_dout !== mkv(51)) begin
      fails++; $display("FAIL simul_rd2 vld %b got %h exp %h", bus.mxm_dout_vld, bus.mxm_dout[31:0], mkv(51) & 32'hFFFFFFFF);
    end
    tests++; if (bus.mxm_empty !== 1'b1) begin fails++; $display("FAIL simul_empty got %b exp 1", bus.mxm_empty); end
  endtask

  task automatic test_start_mid();
    int exp_vld [5];
    int exp_idx [5];
    exp_vld = '{1, 1, 0, 1, 1};
    exp_idx = '{80, 81, 0, 80, 81};
    do_start(16'd3);
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1; bus.din = mkv(60 + i); tick();
    end
    bus.wr_en = 1'b0;
    bus.mxm_rd_en = 1'b1; bus.mxm_rd_last_rnd = 1'b0;
    tick(); tick();
    start_pulse = 1'b1; vsm1 = 16'd1;
    bus.wr_en = 1'b1; bus.din = mkv(70);
    tick();
    start_pulse = 1'b0; bus.wr_en = 1'b0; bus.mxm_rd_en = 1'b0;
    tests++; if (bus.mxm_empty !== 1'b1) begin fails++; $display("FAIL start_empty got %b exp 1", bus.mxm_empty); end
    tests++; if (bus.mxm_dout_vld !== 1'b0) begin fails++; $display("FAIL start_vld got %b exp 0", bus.mxm_dout_vld); end
    tests++; if (bus.mxm_dout !== mkv(61)) begin fails++; $display("FAIL start_dout_hold got %h exp %h", bus.mxm_dout[31:0], mkv(61) & 32'hFFFFFFFF); end
    for (int i = 0; i < 2; i++) begin
      bus.wr_en = 1'b1; bus.din = mkv(80 + i); tick();
    end
    bus.wr_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.mxm_rd_en = 1'b1;
      bus.mxm_rd_last_rnd = (c >= 3);
      if (c == 2) begin
        tests++; if (bus.mxm_empty !== 1'b1) begin fails++; $display("FAIL start_rewind_empty got %b exp 1", bus.mxm_empty); end
      end
      tick();
      tests++;
      if (bus.mxm_dout_vld !== exp_vld[c][0]) begin
        fails++; $display("FAIL start_vld[%0d] got %b exp %0d", c, bus.mxm_dout_vld, exp_vld[c]);
      end else if (exp_vld[c] == 1 && bus.mxm_dout !== mkv(exp_idx[c])) begin
        fails++; $display("FAIL start_dout[%0d] got %h exp %h", c, bus.mxm_dout[31:0], mkv(exp_idx[c]) & 32'hFFFFFFFF);
      end
    end
    bus.mxm_rd_en = 1'b0; bus.mxm_rd_last_rnd = 1'b0;
    tests++; if (bus.mxm_empty !== 1'b1) begin fails++; $display("FAIL start_end_empty got %b exp 1", bus.mxm_empty); end
  endtask

  initial begin
    rst = 1'b1; start_pulse = 1'b0; vsm1 = '0;
    bus.wr_en = 1'b0; bus.din = '0;
    bus.mxm_rd_en = 1'b0; bus.mxm_rd_last_rnd = 1'b0;
    test_reset();
    test_replay();
    test_wrap();
    test_fill();
    test_simul();
    test_start_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
